hazard_unit: RTL and testbench

//  Combinational pipeline-hazard resolver for the 5-stage PoliRISC-V core. It compares ID-stage

---
 rtl/hazard_unit.sv | 89 ++++++++
 tb/tb_hazard_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Combinational stall/flush resolver for the 5-stage PoliRISC-V pipeline,
// with registered stall/flush event counters for performance monitoring.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       hazard_type,
  input  logic             rs_used,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rd_mem,
  input  logic             reg_we_ex,
  input  logic             reg_we_mem,
  input  logic             mem_rd_en_ex,
  input  logic             mem_rd_en_mem,
  input  logic             store_id,
  input  logic             zicsr_ex,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    NO_HAZARD        = 2'd0,
    HAZARD_DECODE    = 2'd1,
    HAZARD_EXECUTE   = 2'd2,
    HAZARD_EXCEPTION = 2'd3
  } hazard_t;

  function automatic logic match(input logic [4:0] rs, input logic [4:0] rd,
                                 input logic we, input logic en);
    return (rs == rd) && (rd != 5'd0) && we && en;
  endfunction

  logic [4:0] rs2_eff;
  logic       haz_decode;
  logic       haz_execute;

  // A store's rs2 is only store data, so it is read late and escapes load-use.
  always_comb begin
    rs2_eff     = rs_used ? rs2_id : 5'd0;
    haz_decode  = match(rs1_id,  rd_ex,  reg_we_ex,  !zicsr_ex)
               || match(rs2_eff, rd_ex,  reg_we_ex,  !zicsr_ex)
               || match(rs1_id,  rd_mem, reg_we_mem, mem_rd_en_mem)
               || match(rs2_eff, rd_mem, reg_we_mem, mem_rd_en_mem);
    haz_execute = match(rs1_id,  rd_ex, reg_we_ex, mem_rd_en_ex)
               || match(rs2_eff, rd_ex, reg_we_ex, mem_rd_en_ex && !store_id);
  end

  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    case (hazard_t'(hazard_type))
      HAZARD_DECODE: begin
        stall_if = haz_decode;
        stall_id = haz_decode;
        flush_ex = haz_decode;
      end
      HAZARD_EXECUTE: begin
        stall_if = haz_execute;
        stall_id = haz_execute;
        flush_ex = haz_execute;
      end
      HAZARD_EXCEPTION: begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_id) stall_count <= stall_count + 1'b1;
      if (flush_id) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and random checks of hazard_unit outputs and event counters
// against hand-computed values and an independent reference model.
module tb_hazard_unit;

  logic        clock;
  logic        reset_n;
  logic [1:0]  hazard_type;
  logic        rs_used;
  logic [4:0]  rs1_id, rs2_id, rd_ex, rd_mem;
  logic        reg_we_ex, reg_we_mem, mem_rd_en_ex, mem_rd_en_mem, store_id, zicsr_ex;
  logic        stall_if, stall_id, flush_id, flush_ex;
  logic [31:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  hazard_unit #(.CNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .hazard_type(hazard_type), .rs_used(rs_used),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex), .rd_mem(rd_mem),
    .reg_we_ex(reg_we_ex), .reg_we_mem(reg_we_mem), .mem_rd_en_ex(mem_rd_en_ex),
    .mem_rd_en_mem(mem_rd_en_mem), .store_id(store_id), .zicsr_ex(zicsr_ex),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output bundle ordering: {stall_if, stall_id, flush_id, flush_ex}
  localparam logic [3:0] STALL = 4'b1101;
  localparam logic [3:0] EXCPT = 4'b0011;
  localparam logic [3:0] NONE  = 4'b0000;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ht, input logic used,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rex, input logic [4:0] rmem,
                               input logic wex, input logic wmem,
                               input logic lex, input logic lmem,
                               input logic st, input logic csr);
    hazard_type = ht; rs_used = used; rs1_id = r1; rs2_id = r2;
    rd_ex = rex; rd_mem = rmem; reg_we_ex = wex; reg_we_mem = wmem;
    mem_rd_en_ex = lex; mem_rd_en_mem = lmem; store_id = st; zicsr_ex = csr;
    #1;
  endtask

  function automatic logic [3:0] model(input logic [1:0] ht, input logic used,
                                       input logic [4:0] r1, input logic [4:0] r2,
                                       input logic [4:0] rex, input logic [4:0] rmem,
                                       input logic wex, input logic wmem,
                                       input logic lex, input logic lmem,
                                       input logic st, input logic csr);
    logic       hz;
    logic [4:0] s2;
    s2 = used ? r2 : 5'd0;
    hz = 1'b0;
    if (ht == 2'd3) return EXCPT;
    if (ht == 2'd1) begin
      if (rex != 0 && wex && !csr && (r1 == rex || s2 == rex)) hz = 1'b1;
      if (rmem != 0 && wmem && lmem && (r1 == rmem || s2 == rmem)) hz = 1'b1;
    end else if (ht == 2'd2) begin
      if (rex != 0 && wex && lex) begin
        if (r1 == rex) hz = 1'b1;
        if (s2 == rex && !st) hz = 1'b1;
      end
    end
    return hz ? STALL : NONE;
  endfunction

  function automatic logic [31:0] outs();
    return {28'd0, stall_if, stall_id, flush_id, flush_ex};
  endfunction

  logic [3:0]  exp_out, prev_exp;
  logic [31:0] exp_stall, exp_flush;
  logic [1:0]  r_ht;
  logic        r_used, r_wex, r_wmem, r_lex, r_lmem, r_st, r_csr;
  logic [4:0]  r_r1, r_r2, r_rex, r_rmem;

  initial begin
    reset_n = 1'b0;
    applyStimulus(2'd1, 1'b0, 5'd5, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_stall_count", stall_count, 32'd0);
    checkOutput("reset_flush_count", flush_count, 32'd0);
    checkOutput("comb_during_reset", outs(), {28'd0, STALL});
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Decode mode, EX forward-able producer and zicsr exemption
    applyStimulus(2'd1, 1'b0, 5'd5, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("dec_ex_match", outs(), {28'd0, STALL});
    applyStimulus(2'd1, 1'b0, 5'd5, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("dec_ex_zicsr", outs(), {28'd0, NONE});
    // Decode mode, MEM load producer
    applyStimulus(2'd1, 1'b0, 5'd3, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("dec_mem_load", outs(), {28'd0, STALL});
    applyStimulus(2'd1, 1'b0, 5'd3, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("dec_mem_noload", outs(), {28'd0, NONE});
    // Decode mode, EX and MEM both matching
    applyStimulus(2'd1, 1'b1, 5'd4, 5'd6, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("dec_double", outs(), {28'd0, STALL});
    // Execute mode load-use through rs2, store exemption, rs1 not exempt
    applyStimulus(2'd2, 1'b1, 5'd1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("exe_rs2", outs(), {28'd0, STALL});
    applyStimulus(2'd2, 1'b1, 5'd1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("exe_rs2_store", outs(), {28'd0, NONE});
    applyStimulus(2'd2, 1'b1, 5'd7, 5'd2, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("exe_rs1_store", outs(), {28'd0, STALL});
    applyStimulus(2'd2, 1'b0, 5'd7, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("exe_not_load", outs(), {28'd0, NONE});
    // x0 never hazards; unused rs2 ignored
    applyStimulus(2'd1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("x0_decode", outs(), {28'd0, NONE});
    applyStimulus(2'd2, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("x0_execute", outs(), {28'd0, NONE});
    applyStimulus(2'd1, 1'b0, 5'd1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rs2_unused_dec", outs(), {28'd0, NONE});
    applyStimulus(2'd2, 1'b0, 5'd1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rs2_unused_exe", outs(), {28'd0, NONE});
    // Exception and NoHazard with matching operands
    applyStimulus(2'd3, 1'b1, 5'd5, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("exception", outs(), {28'd0, EXCPT});
    applyStimulus(2'd0, 1'b1, 5'd5, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("no_hazard", outs(), {28'd0, NONE});

    // Counters: asynchronous clear mid-run, then 3 stall cycles and 2 exception cycles
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midrun_stall_clr", stall_count, 32'd0);
    checkOutput("midrun_flush_clr", flush_count, 32'd0);
    reset_n = 1'b1;
    applyStimulus(2'd1, 1'b0, 5'd5, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    applyStimulus(2'd3, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    applyStimulus(2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_count_3", stall_count, 32'd3);
    checkOutput("flush_count_2", flush_count, 32'd2);

    // Random vectors against the reference model, counters tracked alongside
    exp_stall = 32'd3;
    exp_flush = 32'd2;
    prev_exp  = NONE;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clock);
      if (prev_exp[2]) exp_stall = exp_stall + 1;
      if (prev_exp[1]) exp_flush = exp_flush + 1;
      #1;
      checkOutput("rand_stall_count", stall_count, exp_stall);
      checkOutput("rand_flush_count", flush_count, exp_flush);
      r_ht   = 2'($urandom_range(0, 3));
      r_used = 1'($urandom);
      r_r1   = 5'($urandom_range(0, 3));
      r_r2   = 5'($urandom_range(0, 3));
      r_rex  = 5'($urandom_range(0, 3));
      r_rmem = 5'($urandom_range(0, 3));
      r_wex  = 1'($urandom);
      r_wmem = 1'($urandom);
      r_lex  = 1'($urandom);
      r_lmem = 1'($urandom);
      r_st   = 1'($urandom);
      r_csr  = 1'($urandom);
      applyStimulus(r_ht, r_used, r_r1, r_r2, r_rex, r_rmem, r_wex, r_wmem, r_lex, r_lmem, r_st, r_csr);
      exp_out = model(r_ht, r_used, r_r1, r_r2, r_rex, r_rmem, r_wex, r_wmem, r_lex, r_lmem, r_st, r_csr);
      checkOutput("rand_outputs", outs(), {28'd0, exp_out});
      prev_exp = exp_out;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
